// File: rtl/wb_stage_fwd_reg.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage_fwd_reg
// Brief    : MEM/WB pipeline register with stall/flush, retired-write history
//            and combinational forwarding lookups (youngest match wins).
//            Optional macro WB_HIST_CLR_EN adds a synchronous history clear.
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage_fwd_reg #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int HIST_DEPTH = 2,
  parameter int NUM_LOOKUP = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_in,
  input  logic                         flush_in,
`ifdef WB_HIST_CLR_EN
  input  logic                         hist_clr,
`endif
  input  logic                         valid_in,
  input  logic                         RegWrite_in,
  input  logic [DATA_W-1:0]            data_in,
  input  logic [ADDR_W-1:0]            dst_in,
  output logic                         valid,
  output logic                         RegWrite,
  output logic [DATA_W-1:0]            wb_data,
  output logic [ADDR_W-1:0]            wb_dst,
  input  logic [NUM_LOOKUP*ADDR_W-1:0] lk_addr,
  output logic [NUM_LOOKUP-1:0]        lk_hit,
  output logic [NUM_LOOKUP*DATA_W-1:0] lk_data,
  output logic [3:0]                   hist_count
);

  localparam logic [3:0] HIST_MAX = 4'(HIST_DEPTH);

  logic [HIST_DEPTH-1:0] hist_vld;
  logic [ADDR_W-1:0]     hist_addr [HIST_DEPTH];
  logic [DATA_W-1:0]     hist_data [HIST_DEPTH];
  logic                  commit;
  logic                  clr;

  // A flush still lets the outgoing instruction retire; only a plain stall holds it.
  assign commit = RegWrite & (~stall_in | flush_in);

`ifdef WB_HIST_CLR_EN
  assign clr = hist_clr;
`else
  assign clr = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid    <= 1'b0;
      RegWrite <= 1'b0;
      wb_data  <= '0;
      wb_dst   <= '0;
    end else if (flush_in) begin
      valid    <= 1'b0;
      RegWrite <= 1'b0;
      wb_data  <= '0;
      wb_dst   <= '0;
    end else if (!stall_in) begin
      valid    <= valid_in;
      RegWrite <= RegWrite_in & valid_in & (dst_in != '0);
      wb_data  <= data_in;
      wb_dst   <= dst_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_vld   <= '0;
      hist_count <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (clr) begin
      hist_vld   <= '0;
      hist_count <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_addr[i] <= '0;
        hist_data[i] <= '0;
      end
    end else if (commit) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_vld[i]  <= hist_vld[i-1];
        hist_addr[i] <= hist_addr[i-1];
        hist_data[i] <= hist_data[i-1];
      end
      hist_vld[0]  <= 1'b1;
      hist_addr[0] <= wb_dst;
      hist_data[0] <= wb_data;
      if (hist_count < HIST_MAX) begin
        hist_count <= hist_count + 4'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_LOOKUP; k++) begin : g_lookup
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic [DATA_W-1:0] data;

    assign addr = lk_addr[k*ADDR_W +: ADDR_W];

    // Walk oldest to youngest so later (younger) matches overwrite earlier ones.
    always_comb begin
      hit  = 1'b0;
      data = '0;
      for (int i = HIST_DEPTH - 1; i >= 0; i--) begin
        if (hist_vld[i] && (hist_addr[i] == addr)) begin
          hit  = 1'b1;
          data = hist_data[i];
        end
      end
      if (RegWrite && (wb_dst == addr)) begin
        hit  = 1'b1;
        data = wb_data;
      end
      if (addr == '0) begin
        hit  = 1'b0;
        data = '0;
      end
    end

    assign lk_hit[k]                   = hit;
    assign lk_data[k*DATA_W +: DATA_W] = data;
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_fwd_reg.sv
`default_nettype none
// Directed self-checking bench for wb_stage_fwd_reg (default parameters).
module tb_wb_stage_fwd_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic        hist_clr = 1'b0;
  logic        valid_in = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [4:0]  dst_in = '0;
  logic        valid;
  logic        RegWrite;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst;
  logic [9:0]  lk_addr = '0;
  logic [1:0]  lk_hit;
  logic [63:0] lk_data;
  logic [3:0]  hist_count;

  int checks = 0;
  int failures = 0;

  wb_stage_fwd_reg dut (
    .clk        (clk),
    .reset      (reset),
    .stall_in   (stall_in),
    .flush_in   (flush_in),
`ifdef WB_HIST_CLR_EN
    .hist_clr   (hist_clr),
`endif
    .valid_in   (valid_in),
    .RegWrite_in(RegWrite_in),
    .data_in    (data_in),
    .dst_in     (dst_in),
    .valid      (valid),
    .RegWrite   (RegWrite),
    .wb_data    (wb_data),
    .wb_dst     (wb_dst),
    .lk_addr    (lk_addr),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data),
    .hist_count (hist_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] d, input logic [31:0] x);
    valid_in = v; RegWrite_in = rw; dst_in = d; data_in = x;
  endtask

  task automatic do_reset();
    stall_in = 0; flush_in = 0; hist_clr = 0; lk_addr = '0;
    drive(0, 0, 0, 0);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid, RegWrite, wb_data, wb_dst} !== 39'd0) begin
      failures++;
      $display("FAIL reset_stage: got v=%0b rw=%0b d=%h a=%0d, want all 0", valid, RegWrite, wb_data, wb_dst);
    end
    checks++;
    if (hist_count !== 4'd0) begin
      failures++; $display("FAIL reset_count: got %0d want 0", hist_count);
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    drive(1, 1, 5'd5, 32'hDEADBEEF);
    step();
    checks++;
    if ({valid, RegWrite, wb_dst, wb_data} !== {1'b1, 1'b1, 5'd5, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL pass_r5: got v=%0b rw=%0b a=%0d d=%h, want 1 1 5 deadbeef", valid, RegWrite, wb_dst, wb_data);
    end
    lk_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if ({lk_hit[0], lk_data[31:0]} !== {1'b1, 32'hDEADBEEF}) begin
      failures++; $display("FAIL lk_stage: got hit=%0b d=%h want 1 deadbeef", lk_hit[0], lk_data[31:0]);
    end
    checks++;
    if ({lk_hit[1], lk_data[63:32]} !== 33'd0) begin
      failures++; $display("FAIL lk_zero_addr: got hit=%0b d=%h want 0 0", lk_hit[1], lk_data[63:32]);
    end
    drive(1, 1, 5'd0, 32'h1234);
    step();
    checks++;
    if ({valid, RegWrite, wb_dst} !== {1'b1, 1'b0, 5'd0}) begin
      failures++; $display("FAIL pass_r0: got v=%0b rw=%0b a=%0d want 1 0 0", valid, RegWrite, wb_dst);
    end
    lk_addr = {5'd5, 5'd0};
    #1;
    checks++;
    if ({hist_count, lk_hit[1], lk_data[63:32]} !== {4'd1, 1'b1, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL pass_hist: got cnt=%0d hit=%0b d=%h want 1 1 deadbeef", hist_count, lk_hit[1], lk_data[63:32]);
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    drive(1, 1, 5'd5, 32'hDEADBEEF);
    step();
    drive(1, 1, 5'd9, 32'h99);
    stall_in = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({RegWrite, wb_dst, wb_data, hist_count} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd0}) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got rw=%0b a=%0d d=%h cnt=%0d want 1 5 deadbeef 0",
                 i, RegWrite, wb_dst, wb_data, hist_count);
      end
    end
    flush_in = 1;
    step();
    stall_in = 0; flush_in = 0;
    drive(0, 0, 0, 0);
    checks++;
    if ({valid, RegWrite, wb_dst, wb_data, hist_count} !== {1'b0, 1'b0, 5'd0, 32'd0, 4'd1}) begin
      failures++;
      $display("FAIL flush_bubble: got v=%0b rw=%0b a=%0d d=%h cnt=%0d want 0 0 0 0 1",
               valid, RegWrite, wb_dst, wb_data, hist_count);
    end
    lk_addr = {5'd9, 5'd5};
    #1;
    checks++;
    if ({lk_hit, lk_data[31:0]} !== {2'b01, 32'hDEADBEEF}) begin
      failures++; $display("FAIL flush_push: got hit=%b d=%h want 01 deadbeef", lk_hit, lk_data[31:0]);
    end
  endtask

  task automatic test_hist_depth();
    do_reset();
    drive(1, 1, 5'd1, 32'h11); step();
    drive(1, 1, 5'd2, 32'h22); step();
    drive(1, 1, 5'd3, 32'h33); step();
    drive(0, 0, 0, 0);         step();
    checks++;
    if (hist_count !== 4'd2) begin
      failures++; $display("FAIL depth_count: got %0d want 2", hist_count);
    end
    lk_addr = {5'd2, 5'd1};
    #1;
    checks++;
    if ({lk_hit, lk_data} !== {2'b10, 32'h22, 32'h0}) begin
      failures++; $display("FAIL depth_r1_r2: got hit=%b d=%h want 10 0000002200000000", lk_hit, lk_data);
    end
    lk_addr = {5'd0, 5'd3};
    #1;
    checks++;
    if ({lk_hit, lk_data[31:0]} !== {2'b01, 32'h33}) begin
      failures++; $display("FAIL depth_r3: got hit=%b d=%h want 01 33", lk_hit, lk_data[31:0]);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 1, 5'd4, 32'hAA); step();
    drive(1, 1, 5'd4, 32'hBB); step();
    drive(1, 1, 5'd4, 32'hCC); step();
    drive(0, 0, 0, 0);
    lk_addr = {5'd4, 5'd4};
    #1;
    checks++;
    if ({lk_hit, lk_data} !== {2'b11, 32'hCC, 32'hCC}) begin
      failures++; $display("FAIL young_stage: got hit=%b d=%h want 11 cc/cc", lk_hit, lk_data);
    end
    // The bubble lets CC retire into history entry 0.
    step();
    checks++;
    if ({RegWrite, hist_count, lk_hit[0], lk_data[31:0]} !== {1'b0, 4'd2, 1'b1, 32'hCC}) begin
      failures++;
      $display("FAIL young_hist: got rw=%0b cnt=%0d hit=%0b d=%h want 0 2 1 cc",
               RegWrite, hist_count, lk_hit[0], lk_data[31:0]);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    drive(1, 1, 5'd6, 32'h66); step();
    drive(1, 1, 5'd8, 32'h88); step();
    lk_addr = {5'd8, 5'd6};
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({valid, RegWrite, wb_data, wb_dst, hist_count, lk_hit} !== 45'd0) begin
      failures++;
      $display("FAIL midrun_reset: got v=%0b rw=%0b d=%h a=%0d cnt=%0d hit=%b want all 0",
               valid, RegWrite, wb_data, wb_dst, hist_count, lk_hit);
    end
    #1 reset = 1'b1;
    drive(0, 0, 0, 0);
    step();
  endtask

`ifdef WB_HIST_CLR_EN
  task automatic test_hist_clr();
    do_reset();
    drive(1, 1, 5'd7, 32'h77); step();
    drive(0, 0, 0, 0);
    hist_clr = 1;
    step();
    hist_clr = 0;
    lk_addr = {5'd0, 5'd7};
    #1;
    checks++;
    if ({hist_count, lk_hit[0], lk_data[31:0]} !== {4'd0, 1'b0, 32'd0}) begin
      failures++;
      $display("FAIL hist_clr: got cnt=%0d hit=%0b d=%h want 0 0 0", hist_count, lk_hit[0], lk_data[31:0]);
    end
  endtask
`endif

  initial begin
    #3;
    test_reset();
    test_pass_through();
    test_stall_flush();
    test_hist_depth();
    test_youngest();
    test_reset_midrun();
`ifdef WB_HIST_CLR_EN
    test_hist_clr();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
